mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 24 ++
 rtl/mem_ctrl_if.sv | 27 ++
 rtl/mem_ctrl.sv | 96 +++++++++
 tb/tb_mem_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared codes for mem_ctrl: request codes, RAM owner codes, IF fetch FSM states.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'b00,
    REQ_LOAD  = 2'b01,
    REQ_STORE = 2'b10
  } req_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_MEM  = 2'b10
  } own_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_DONE  = 2'b10
  } if_state_e;

  localparam logic [2:0] INST_BYTES = 3'd4;

endpackage

// File: rtl/mem_ctrl_if.sv
// IF fetch, MEM byte access and RAM-side signals of mem_ctrl.
interface mem_ctrl_if;
  logic        if_request;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] inst_o;
  logic        inst_valid;
  logic [1:0]  mem_request;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data_i;
  logic [7:0]  mem_data_o;
  logic [1:0]  if_or_mem;
  logic [31:0] ram_addr;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;

  // slave: the controller; master: the IF/MEM stages and the RAM around it
  modport slave (
    input  if_request, if_addr, if_flush, mem_request, mem_addr, mem_data_i, ram_din,
    output inst_o, inst_valid, mem_data_o, if_or_mem, ram_addr, ram_dout, ram_wr
  );
  modport master (
    output if_request, if_addr, if_flush, mem_request, mem_addr, mem_data_i, ram_din,
    input  inst_o, inst_valid, mem_data_o, if_or_mem, ram_addr, ram_dout, ram_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates a byte-wide single-port RAM between MEM (priority) and a 4-byte IF fetch.
// Optional MEM_CTRL_FLUSH_EN: if_flush aborts an in-progress fetch.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input logic      clk,
  input logic      rst,
  mem_ctrl_if.slave bus
);

  if_state_e   state, state_nx;
  own_e        owner_q, owner_nx;
  logic [31:0] base;
  logic [2:0]  issue_cnt, recv_cnt;
  logic [31:0] buf_q;
  logic [31:0] inst_q;
  logic        mem_act, issue, capture, flush;

`ifdef MEM_CTRL_FLUSH_EN
  assign flush = bus.if_flush;
`else
  logic unused_flush;
  assign unused_flush = bus.if_flush;
  assign flush        = 1'b0;
`endif

  assign mem_act = (bus.mem_request != REQ_NONE);
  assign issue   = (state == S_FETCH) && !mem_act && (issue_cnt < INST_BYTES);
  // A byte returning after a flush or reset lands while not in FETCH, so it is dropped.
  assign capture = (state == S_FETCH) && (owner_q == OWN_IF);

  always_comb begin
    bus.ram_addr = 32'd0;
    bus.ram_wr   = 1'b0;
    bus.ram_dout = 8'd0;
    owner_nx     = OWN_NONE;
    if (mem_act) begin
      bus.ram_addr = bus.mem_addr;
      bus.ram_wr   = (bus.mem_request == REQ_STORE);
      bus.ram_dout = bus.mem_data_i;
      owner_nx     = OWN_MEM;
    end else if (issue) begin
      bus.ram_addr = base + {29'd0, issue_cnt};
      owner_nx     = OWN_IF;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.if_request) state_nx = S_FETCH;
      S_FETCH: if (capture && recv_cnt == INST_BYTES - 3'd1) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      owner_q   <= OWN_NONE;
      base      <= 32'd0;
      issue_cnt <= 3'd0;
      recv_cnt  <= 3'd0;
      buf_q     <= 32'd0;
      inst_q    <= 32'd0;
    end else begin
      state   <= state_nx;
      owner_q <= owner_nx;
      if (flush) begin
        issue_cnt <= 3'd0;
        recv_cnt  <= 3'd0;
      end else begin
        if (state == S_IDLE && bus.if_request) begin
          base      <= bus.if_addr;
          issue_cnt <= 3'd0;
          recv_cnt  <= 3'd0;
        end
        if (issue) issue_cnt <= issue_cnt + 3'd1;
        if (capture) begin
          buf_q[{recv_cnt[1:0], 3'b000} +: 8] <= bus.ram_din;
          recv_cnt <= recv_cnt + 3'd1;
          // Last byte goes straight into the output word so inst_o is ready in DONE.
          if (recv_cnt == INST_BYTES - 3'd1) inst_q <= {bus.ram_din, buf_q[23:0]};
        end
      end
    end
  end

  assign bus.inst_o     = inst_q;
  assign bus.inst_valid = (state == S_DONE);
  assign bus.mem_data_o = bus.ram_din;
  assign bus.if_or_mem  = owner_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, scoreboard of expected fetch words and their cycles.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_ctrl_if bus ();
  mem_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  // 4 KiB RAM window; every address used below is distinct in its low 12 bits
  logic [7:0] ram [4096];
  always @(posedge clk) begin
    if (bus.ram_wr) ram[bus.ram_addr[11:0]] <= bus.ram_dout;
    bus.ram_din <= ram[bus.ram_addr[11:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] word;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.inst_valid === 1'b1) begin
      if (sb.size() == 0) chk("spurious_valid", {31'd0, bus.inst_valid}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("inst_o", bus.inst_o, e.word);
        chk("valid_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [7:0] d);
    bus.mem_request = REQ_STORE;
    bus.mem_addr    = a;
    bus.mem_data_i  = d;
    step();
    bus.mem_request = REQ_NONE;
  endtask

  task automatic drain;
    for (int i = 0; i < 30 && sb.size() != 0; i++) step();
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  // Uncontended fetch: checks the four issued addresses, scoreboard checks word and T+6
  task automatic fetch(input logic [31:0] a, input logic [31:0] w);
    bus.if_request = 1'b1;
    bus.if_addr    = a;
    sb.push_back('{w, cyc + 6});
    step();
    bus.if_request = 1'b0;
    bus.if_addr    = $urandom;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("issue_addr", bus.ram_addr, a + i);
      step();
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.if_request  = 1'b0;
    bus.if_addr     = 32'd0;
    bus.if_flush    = 1'b0;
    bus.mem_request = REQ_NONE;
    bus.mem_addr    = 32'd0;
    bus.mem_data_i  = 8'd0;
    rst = 1'b1;
    step(); step();
    @(negedge clk);
    chk("rst_inst_o", bus.inst_o, 32'd0);
    chk("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_owner", {30'd0, bus.if_or_mem}, 32'd0);
    chk("rst_ram_addr", bus.ram_addr, 32'd0);
    chk("rst_ram_wr", {31'd0, bus.ram_wr}, 32'd0);
    step();
    rst = 1'b0;

    // preload through the MEM store path
    store(32'h100, 8'h13); store(32'h101, 8'h05); store(32'h102, 8'h00); store(32'h103, 8'h00);
    store(32'h200, 8'hA5);
    store(32'h300, 8'h93); store(32'h301, 8'h00); store(32'h302, 8'h10); store(32'h303, 8'h00);
    store(32'h400, 8'hEF); store(32'h401, 8'hBE); store(32'h402, 8'hAD); store(32'h403, 8'hDE);
    store(32'hFFFF_FFFE, 8'h37); store(32'hFFFF_FFFF, 8'h12);
    store(32'h0, 8'h34); store(32'h1, 8'h56);

    // MEM store then load in IDLE
    bus.mem_request = REQ_STORE; bus.mem_addr = 32'h40; bus.mem_data_i = 8'h7E;
    @(negedge clk);
    chk("st_ram_wr", {31'd0, bus.ram_wr}, 32'd1);
    chk("st_ram_addr", bus.ram_addr, 32'h40);
    chk("st_ram_dout", {24'd0, bus.ram_dout}, 32'h7E);
    step();
    bus.mem_request = REQ_LOAD; bus.mem_data_i = 8'h00;
    @(negedge clk);
    chk("ld_ram_wr", {31'd0, bus.ram_wr}, 32'd0);
    chk("ld_owner_prev", {30'd0, bus.if_or_mem}, {30'd0, OWN_MEM});
    step();
    bus.mem_request = REQ_NONE; bus.mem_addr = 32'h0;
    @(negedge clk);
    chk("ld_data", {24'd0, bus.mem_data_o}, 32'h7E);
    chk("idle_ram_addr", bus.ram_addr, 32'd0);
    chk("idle_ram_wr", {31'd0, bus.ram_wr}, 32'd0);
    step();
    @(negedge clk);
    chk("idle_owner", {30'd0, bus.if_or_mem}, {30'd0, OWN_NONE});
    step();

    fetch(32'h100, 32'h0000_0513);
    fetch(32'h400, 32'hDEAD_BEEF);

    // MEM load preempting a fetch at T+2 adds one cycle
    bus.if_request = 1'b1; bus.if_addr = 32'h100;
    sb.push_back('{32'h0000_0513, cyc + 7});
    step();
    bus.if_request = 1'b0; bus.if_addr = 32'hDEAD_0000;
    @(negedge clk);
    chk("pre_issue0", bus.ram_addr, 32'h100);
    chk("pre_owner_none", {30'd0, bus.if_or_mem}, {30'd0, OWN_NONE});
    step();
    bus.mem_request = REQ_LOAD; bus.mem_addr = 32'h200;
    @(negedge clk);
    chk("pre_mem_addr", bus.ram_addr, 32'h200);
    chk("pre_mem_wr", {31'd0, bus.ram_wr}, 32'd0);
    step();
    bus.mem_request = REQ_NONE; bus.mem_addr = 32'h0;
    @(negedge clk);
    chk("pre_ld_data", {24'd0, bus.mem_data_o}, 32'hA5);
    chk("pre_owner_mem", {30'd0, bus.if_or_mem}, {30'd0, OWN_MEM});
    chk("pre_resume", bus.ram_addr, 32'h101);
    step();
    drain();

    fetch(32'hFFFF_FFFE, 32'h5634_1237);

    // Reset mid-fetch at T+3, new fetch at T+4
    bus.if_request = 1'b1; bus.if_addr = 32'h300;
    step();
    bus.if_request = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.if_request = 1'b1; bus.if_addr = 32'h400;
    sb.push_back('{32'hDEAD_BEEF, cyc + 6});
    @(negedge clk);
    chk("mrst_inst_o", bus.inst_o, 32'd0);
    chk("mrst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("mrst_owner", {30'd0, bus.if_or_mem}, 32'd0);
    chk("mrst_ram_addr", bus.ram_addr, 32'd0);
    chk("mrst_ram_wr", {31'd0, bus.ram_wr}, 32'd0);
    step();
    bus.if_request = 1'b0;
    drain();

    // Flush at T+3
    bus.if_request = 1'b1; bus.if_addr = 32'h300;
`ifndef MEM_CTRL_FLUSH_EN
    sb.push_back('{32'h0010_0093, cyc + 6});
`endif
    step();
    bus.if_request = 1'b0;
    step(); step();
    bus.if_flush = 1'b1;
    step();
    bus.if_flush = 1'b0;
`ifdef MEM_CTRL_FLUSH_EN
    bus.if_request = 1'b1; bus.if_addr = 32'h100;
    sb.push_back('{32'h0000_0513, cyc + 6});
    @(negedge clk);
    chk("fl_ram_addr", bus.ram_addr, 32'd0);
    step();
    bus.if_request = 1'b0;
`endif
    drain();

    fetch(32'h300, 32'h0010_0093);
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
